// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: ISA fields,
// datapath select codes, FSM states and the opcode/funct decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RD = 2'd0;
    localparam logic [1:0] REG_DST_RT = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] REG_SRC_ALU = 2'd0;
    localparam logic [1:0] REG_SRC_MEM = 2'd1;
    localparam logic [1:0] REG_SRC_PC4 = 2'd2;

    localparam logic [1:0] ALU_B_RT   = 2'd0;
    localparam logic [1:0] ALU_B_SIMM = 2'd1;
    localparam logic [1:0] ALU_B_ZIMM = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        INS_ILLEGAL,
        INS_ADD,
        INS_SUB,
        INS_SLT,
        INS_JR,
        INS_J,
        INS_JAL,
        INS_ADDI,
        INS_XORI,
        INS_BEQ,
        INS_BNE,
        INS_LW,
        INS_SW
    } instr_t;

    // Anything outside the supported subset collapses to INS_ILLEGAL.
    function automatic instr_t decode_instr(input logic [5:0] opcode,
                                            input logic [5:0] funct);
        instr_t ins;
        ins = INS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ins = INS_ADD;
                    FN_SUB:  ins = INS_SUB;
                    FN_SLT:  ins = INS_SLT;
                    FN_JR:   ins = INS_JR;
                    default: ins = INS_ILLEGAL;
                endcase
            end
            OP_J:    ins = INS_J;
            OP_JAL:  ins = INS_JAL;
            OP_BEQ:  ins = INS_BEQ;
            OP_BNE:  ins = INS_BNE;
            OP_ADDI: ins = INS_ADDI;
            OP_XORI: ins = INS_XORI;
            OP_LW:   ins = INS_LW;
            OP_SW:   ins = INS_SW;
            default: ins = INS_ILLEGAL;
        endcase
        return ins;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory handshake watchdog: counts cycles a request sits unacknowledged and
// flags expiry when the count reaches MAX_COUNT with the request still pending.
module mem_wait_timer #(
    parameter int MAX_COUNT = 255,
    parameter int W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [W-1:0] count;

    assign expired = count_en && (count == W'(MAX_COUNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions and expose illegal_instr.
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_src,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       instr_done,
    output logic       halted,
    output logic       mem_timeout,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic [2:0] dbg_state
);

    state_t state;
    state_t next_state;
    instr_t instr;
    logic   timer_clear;
    logic   timer_count_en;
    logic   timer_expired;
    logic   timeout_q;

    assign instr = decode_instr(opcode, funct);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timer_expired) begin
                    next_state = HALT;
                end
            end
            DECODE: begin
                case (instr)
                    INS_J: next_state = FETCH;
                    INS_ILLEGAL: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        next_state = HALT;
`else
                        next_state = FETCH;
`endif
                    end
                    default: next_state = EXEC;
                endcase
            end
            EXEC: begin
                case (instr)
                    INS_ADD, INS_SUB, INS_SLT, INS_ADDI, INS_XORI: next_state = WB;
                    INS_LW, INS_SW:                                next_state = MEM;
                    default:                                       next_state = FETCH;
                endcase
            end
            MEM: begin
                // A late mem_ready beats the watchdog in the same cycle.
                if (mem_ready) begin
                    next_state = (instr == INS_LW) ? WB : FETCH;
                end else if (timer_expired) begin
                    next_state = HALT;
                end
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Memory port: mem_req is a level held until the cycle mem_ready is high;
    // that cycle completes the access and mem_we is only meaningful with mem_req.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PC4;
        reg_we       = 1'b0;
        reg_dst      = REG_DST_RD;
        reg_src      = REG_SRC_ALU;
        alu_op       = ALU_ADD;
        alu_src_b    = ALU_B_RT;
        instr_done   = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_PC4;
                end
            end
            DECODE: begin
                case (instr)
                    INS_J: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        instr_done = 1'b1;
                    end
                    INS_ILLEGAL: begin
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
                        instr_done = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            EXEC: begin
                case (instr)
                    INS_ADD: alu_op = ALU_ADD;
                    INS_SUB: alu_op = ALU_SUB;
                    INS_SLT: alu_op = ALU_SLT;
                    INS_JR: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_SRC_RS;
                        instr_done = 1'b1;
                    end
                    INS_JAL: begin
                        reg_we     = 1'b1;
                        reg_dst    = REG_DST_RA;
                        reg_src    = REG_SRC_PC4;
                        pc_we      = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        instr_done = 1'b1;
                    end
                    INS_ADDI, INS_LW, INS_SW: begin
                        alu_op    = ALU_ADD;
                        alu_src_b = ALU_B_SIMM;
                    end
                    INS_XORI: begin
                        alu_op    = ALU_XOR;
                        alu_src_b = ALU_B_ZIMM;
                    end
                    INS_BEQ, INS_BNE: begin
                        // rs ^ rt == 0 exactly when the operands are equal.
                        alu_op     = ALU_XOR;
                        alu_src_b  = ALU_B_RT;
                        pc_we      = (instr == INS_BEQ) ? alu_zero : !alu_zero;
                        pc_src     = PC_SRC_BRANCH;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (instr == INS_SW);
                instr_done   = mem_ready && (instr == INS_SW);
            end
            WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                case (instr)
                    INS_ADD, INS_SUB, INS_SLT: reg_dst = REG_DST_RD;
                    default:                   reg_dst = REG_DST_RT;
                endcase
                reg_src = (instr == INS_LW) ? REG_SRC_MEM : REG_SRC_ALU;
            end
            default: ;
        endcase
    end

    // Outside FETCH/MEM mem_req is low, so the counter is already zero on entry.
    assign timer_clear    = !mem_req || mem_ready;
    assign timer_count_en = mem_req && !mem_ready;

    mem_wait_timer #(
        .MAX_COUNT (MEM_WAIT_MAX),
        .W         (TIMER_W)
    ) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (timer_count_en),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (timer_expired) begin
            timeout_q <= 1'b1;
        end
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state == DECODE && instr == INS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
`endif

    assign halted      = (state == HALT);
    assign mem_timeout = timeout_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomised instruction stream for mips_multicycle_ctrl; a per-instruction
// reference model queues the expected per-cycle control word for the monitor.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int W = 21;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic       instr_done;
    logic       halted;
    logic       mem_timeout;
    logic       illegal_instr;
  } ctl_t;

  typedef enum {K_ADD, K_SUB, K_SLT, K_JR, K_J, K_JAL, K_ADDI, K_XORI,
                K_BEQ, K_BNE, K_LW, K_SW, K_ILL} kind_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0] pc_src, reg_dst, reg_src, alu_src_b;
  logic [2:0] alu_op;
  logic       instr_done, halted, mem_timeout, illegal_w;
  logic [2:0] dbg_state;
  logic [W-1:0] act_v;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  logic [5:0] op_tab [14];
  logic [5:0] fn_tab [14];

  // clock/reset block
  always #5 clk = ~clk;

  mips_multicycle_ctrl #(
    .MEM_WAIT_MAX (WAIT_MAX),
    .TIMER_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .reg_src      (reg_src),
    .alu_op       (alu_op),
    .alu_src_b    (alu_src_b),
    .instr_done   (instr_done),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    .illegal_instr(illegal_w),
`endif
    .dbg_state    (dbg_state)
  );

`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  assign act_v = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
                  reg_dst, reg_src, alu_op, alu_src_b, instr_done, halted,
                  mem_timeout, illegal_w};

  // ISA-level classification of an instruction word.
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20: return K_ADD;
          6'h22: return K_SUB;
          6'h2A: return K_SLT;
          6'h08: return K_JR;
          default: return K_ILL;
        endcase
      end
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h08: return K_ADDI;
      6'h0E: return K_XORI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: one clock cycle of inputs plus the control word expected for it
  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic z, input ctl_t e, input string tag);
    @(posedge clk);
    #1;
    reset = rst;
    opcode = op;
    funct = fn;
    mem_ready = rdy;
    alu_zero = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    ctl_t c;
    c = '0;
    step(1'b1, 6'($urandom), 6'($urandom), rb(), rb(), c, "reset");
    step(1'b1, 6'($urandom), 6'($urandom), rb(), rb(), c, "reset");
    step(1'b0, 6'($urandom), 6'($urandom), rb(), rb(), c, "idle");
  endtask

  task automatic halt_tail(input logic to, input logic ill);
    ctl_t c;
    for (int i = 0; i < 3; i++) begin
      c = '0;
      c.halted = 1'b1;
      c.mem_timeout = to;
      c.illegal_instr = ill;
      step(1'b0, 6'($urandom), 6'($urandom), rb(), rb(), c, "halt");
    end
    do_reset();
  endtask

  // Reference model: one instruction, fw/mw memory wait cycles (> WAIT_MAX means
  // the access never completes), zf forces alu_zero in EXEC when >= 0.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zf);
    kind_e k;
    ctl_t  c;
    logic  z;
    k = classify(op, fn);

    for (int i = 0; i < ((fw > WAIT_MAX) ? WAIT_MAX + 1 : fw); i++) begin
      c = '0;
      c.mem_req = 1'b1;
      step(1'b0, op, fn, 1'b0, rb(), c, "fetch_wait");
    end
    if (fw > WAIT_MAX) begin
      halt_tail(1'b1, 1'b0);
      return;
    end
    c = '0;
    c.mem_req = 1'b1;
    c.ir_we = 1'b1;
    c.pc_we = 1'b1;
    c.pc_src = 2'd0;
    step(1'b0, op, fn, 1'b1, rb(), c, "fetch");

    c = '0;
    if (k == K_J) begin
      c.pc_we = 1'b1;
      c.pc_src = 2'd2;
      c.instr_done = 1'b1;
    end
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
    if (k == K_ILL) c.instr_done = 1'b1;
`endif
    step(1'b0, op, fn, rb(), rb(), c, "decode");
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    if (k == K_ILL) begin
      halt_tail(1'b0, 1'b1);
      return;
    end
`endif
    if (k == K_J || k == K_ILL) return;

    z = (zf >= 0) ? 1'(zf) : rb();
    c = '0;
    case (k)
      K_ADD: begin c.alu_op = 3'd0; c.alu_src_b = 2'd0; end
      K_SUB: begin c.alu_op = 3'd1; c.alu_src_b = 2'd0; end
      K_SLT: begin c.alu_op = 3'd3; c.alu_src_b = 2'd0; end
      K_JR:  begin c.pc_we = 1'b1; c.pc_src = 2'd3; c.instr_done = 1'b1; end
      K_JAL: begin
        c.reg_we = 1'b1; c.reg_dst = 2'd2; c.reg_src = 2'd2;
        c.pc_we = 1'b1; c.pc_src = 2'd2; c.instr_done = 1'b1;
      end
      K_ADDI, K_LW, K_SW: begin c.alu_op = 3'd0; c.alu_src_b = 2'd1; end
      K_XORI: begin c.alu_op = 3'd2; c.alu_src_b = 2'd2; end
      K_BEQ, K_BNE: begin
        c.alu_op = 3'd2; c.alu_src_b = 2'd0; c.pc_src = 2'd1; c.instr_done = 1'b1;
        c.pc_we = (k == K_BEQ) ? z : !z;
      end
      default: ;
    endcase
    step(1'b0, op, fn, rb(), z, c, "exec");
    if (k == K_JR || k == K_JAL || k == K_BEQ || k == K_BNE) return;

    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < ((mw > WAIT_MAX) ? WAIT_MAX + 1 : mw); i++) begin
        c = '0;
        c.mem_req = 1'b1;
        c.mem_addr_sel = 1'b1;
        c.mem_we = (k == K_SW);
        step(1'b0, op, fn, 1'b0, rb(), c, "mem_wait");
      end
      if (mw > WAIT_MAX) begin
        halt_tail(1'b1, 1'b0);
        return;
      end
      c = '0;
      c.mem_req = 1'b1;
      c.mem_addr_sel = 1'b1;
      c.mem_we = (k == K_SW);
      c.instr_done = (k == K_SW);
      step(1'b0, op, fn, 1'b1, rb(), c, "mem");
      if (k == K_SW) return;
    end

    c = '0;
    c.reg_we = 1'b1;
    c.instr_done = 1'b1;
    c.reg_dst = (k == K_ADD || k == K_SUB || k == K_SLT) ? 2'd0 : 2'd1;
    c.reg_src = (k == K_LW) ? 2'd1 : 2'd0;
    step(1'b0, op, fn, rb(), rb(), c, "wb");
  endtask

  // scoreboard monitor: compares every cycle that has an expectation queued
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act_v !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %h required %h (op %02h fn %02h state %0d)",
                 t, $time, act_v, e, opcode, funct, dbg_state);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int idx;
    int fw;
    int mw;
    ctl_t c;
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0E,
               6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F, 6'h00};
    fn_tab = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};

    do_reset();
    run_instr(6'h00, 6'h20, 0, 0, -1);          // ADD, zero wait states
    run_instr(6'h23, 6'h00, 0, 3, -1);          // LW, 3 wait cycles in MEM
    run_instr(6'h04, 6'h00, 0, 0, 1);           // BEQ taken
    run_instr(6'h05, 6'h00, 0, 0, 1);           // BNE not taken
    run_instr(6'h05, 6'h00, 1, 0, 0);           // BNE taken
    run_instr(6'h03, 6'h00, 0, 0, -1);          // JAL
    run_instr(6'h02, 6'h00, 2, 0, -1);          // J
    run_instr(6'h00, 6'h08, 0, 0, -1);          // JR
    run_instr(6'h2B, 6'h00, WAIT_MAX, WAIT_MAX, -1); // SW, ready on the expiry cycle
    run_instr(6'h0E, 6'h00, 0, 0, -1);          // XORI
    run_instr(6'h3F, 6'h00, 0, 0, -1);          // illegal opcode
    run_instr(6'h00, 6'h21, 0, 0, -1);          // illegal funct
    run_instr(6'h08, 6'h00, WAIT_MAX + 1, 0, -1); // fetch timeout
    run_instr(6'h23, 6'h00, 0, WAIT_MAX + 1, -1); // MEM timeout

    // reset in the middle of a fetch
    c = '0;
    c.mem_req = 1'b1;
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, c, "fetch_wait");
    do_reset();

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 13);
      fw = $urandom_range(0, WAIT_MAX);
      mw = $urandom_range(0, WAIT_MAX);
      if ($urandom_range(0, 39) == 0) fw = WAIT_MAX + 1;
      if ($urandom_range(0, 39) == 0) mw = WAIT_MAX + 1;
      run_instr(op_tab[idx], fn_tab[idx], fw, mw, -1);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
